// File: rtl/store_commit_queue_if.sv
// Store commit queue bus bundle.
// Groups the LSU allocate port, the commit-stage handshake, the flush strobe and the
// D$ write request port.
//   slave  : the queue itself (takes LSU/commit/flush/grant, drives ready/status/request)
//   master : the surrounding pipeline and D$ (drives stores, commits, flush and grant)
interface store_commit_queue_if #(
  parameter int unsigned PLEN = 56,
  parameter int unsigned XLEN = 64
) ();
  // Speculative entries are discarded; committed entries are not.
  logic              flush_i;
  // LSU allocate port
  logic              valid_i;
  logic              ready_o;
  logic [PLEN-1:0]   paddr_i;
  logic [XLEN-1:0]   data_i;
  logic [XLEN/8-1:0] be_i;
  // Commit-stage handshake and status
  logic              commit_i;
  logic              commit_ready_o;
  logic              no_st_pending_o;
  // D$ write request port
  logic              req_o;
  logic              gnt_i;
  logic [PLEN-1:0]   addr_o;
  logic [XLEN-1:0]   wdata_o;
  logic [XLEN/8-1:0] be_o;

  modport slave (
    input  flush_i, valid_i, paddr_i, data_i, be_i, commit_i, gnt_i,
    output ready_o, commit_ready_o, no_st_pending_o, req_o, addr_o, wdata_o, be_o
  );

  modport master (
    output flush_i, valid_i, paddr_i, data_i, be_i, commit_i, gnt_i,
    input  ready_o, commit_ready_o, no_st_pending_o, req_o, addr_o, wdata_o, be_o
  );
endinterface

// File: rtl/store_commit_queue.sv
// Store commit queue: buffers stores between execution and the data cache.
// Stores enter as speculative entries, are promoted to committed in order by the
// commit stage, and committed entries drain in order to the D$ request port.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : store_commit_queue_if.slave (allocate, commit, flush, D$ request)
// Entries live in a circular array split by three pointers:
//   [rd_ptr, cm_ptr) committed, awaiting the D$
//   [cm_ptr, wr_ptr) speculative, awaiting commit
// All outputs are functions of registered state only.
module store_commit_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PLEN  = 56,
  parameter int unsigned XLEN  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  store_commit_queue_if.slave   bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BeW  = XLEN / 8;

  logic [PLEN-1:0] paddr_q [DEPTH];
  logic [XLEN-1:0] data_q  [DEPTH];
  logic [BeW-1:0]  be_q    [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] cm_ptr_q, cm_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] n_commit_q, n_commit_d;
  logic [CntW-1:0] n_spec_q, n_spec_d;

  logic [CntW-1:0] occupancy;
  logic            ready;
  logic            commit_ready;
  logic            req;
  logic            do_alloc;
  logic            do_commit;
  logic            do_drain;

  // Occupancy never exceeds DEPTH, so the sum fits in CntW bits.
  assign occupancy    = n_commit_q + n_spec_q;
  assign ready        = occupancy < CntW'(DEPTH);
  assign commit_ready = n_spec_q != '0;
  assign req          = n_commit_q != '0;

  assign bus.ready_o         = ready;
  assign bus.commit_ready_o  = commit_ready;
  assign bus.req_o           = req;
  assign bus.no_st_pending_o = ~req;
  assign bus.addr_o          = paddr_q[rd_ptr_q];
  assign bus.wdata_o         = data_q[rd_ptr_q];
  assign bus.be_o            = be_q[rd_ptr_q];

  // A store arriving in a flush cycle is speculative by definition, so it is dropped.
  assign do_alloc  = bus.valid_i & ready & ~bus.flush_i;
  assign do_commit = bus.commit_i & commit_ready;
  assign do_drain  = req & bus.gnt_i;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    n_commit_d = n_commit_q;
    n_spec_d   = n_spec_q;

    if (do_alloc) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      n_spec_d = n_spec_d + CntW'(1);
    end
    if (do_commit) begin
      cm_ptr_d   = cm_ptr_q + PtrW'(1);
      n_spec_d   = n_spec_d - CntW'(1);
      n_commit_d = n_commit_d + CntW'(1);
    end
    if (do_drain) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      n_commit_d = n_commit_d - CntW'(1);
    end
    // Flush acts after commit: a store committed this cycle stays committed, and the
    // allocate pointer snaps back to the post-commit boundary.
    if (bus.flush_i) begin
      wr_ptr_d = cm_ptr_d;
      n_spec_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      n_commit_q <= '0;
      n_spec_q   <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      n_commit_q <= n_commit_d;
      n_spec_q   <= n_spec_d;
    end
  end

  // Entry contents need no reset; only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      paddr_q[wr_ptr_q] <= bus.paddr_i;
      data_q[wr_ptr_q]  <= bus.data_i;
      be_q[wr_ptr_q]    <= bus.be_i;
    end
  end

  // The datapath ignores these protocol violations, so they are reported, not fatal.
  a_commit_when_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus.commit_i |-> commit_ready
  ) else $warning("commit_i with no speculative entry; ignored");

  a_valid_when_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus.valid_i |-> ready
  ) else $warning("valid_i while queue full; store ignored");

endmodule

// File: tb/tb_store_commit_queue.sv
module tb_store_commit_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PLEN  = 56;
  localparam int unsigned XLEN  = 64;

  logic clk_i;
  logic rst_ni;
  int   checks;
  int   failures;

  store_commit_queue_if #(.PLEN(PLEN), .XLEN(XLEN)) bus ();

  store_commit_queue #(.DEPTH(DEPTH), .PLEN(PLEN), .XLEN(XLEN)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit valid;
    bit commit;
    bit gnt;
    bit flush;
    int st;     // store id driven on the allocate port
    bit e_ready;
    bit e_cr;
    bit e_req;
    bit e_nsp;
    int e_head; // expected head store id, -1 = not checked
  } vec_t;

  function automatic logic [PLEN-1:0] addr_of(input int i);
    if (i == 1) return 56'h0000_0080_0010_00;
    return 56'h4000 + PLEN'(i) * 56'h10;
  endfunction

  function automatic logic [XLEN-1:0] data_of(input int i);
    if (i == 1) return 64'hDEAD_BEEF;
    return {32'hA5A5_0000 ^ 32'(i), 32'(i * 7)};
  endfunction

  function automatic logic [XLEN/8-1:0] be_of(input int i);
    if (i == 1) return 8'h0F;
    return 8'h80 | (8'h01 << (i % 7));
  endfunction

  function automatic vec_t mk(input bit v, input bit c, input bit g, input bit f, input int st,
                              input bit er, input bit ecr, input bit ereq, input bit ensp,
                              input int eh);
    vec_t r;
    r.valid = v; r.commit = c; r.gnt = g; r.flush = f; r.st = st;
    r.e_ready = er; r.e_cr = ecr; r.e_req = ereq; r.e_nsp = ensp; r.e_head = eh;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input bit er, input bit ecr, input bit ereq,
                              input bit ensp);
    check({tag, " ready"}, 64'(bus.ready_o), 64'(er));
    check({tag, " commit_ready"}, 64'(bus.commit_ready_o), 64'(ecr));
    check({tag, " req"}, 64'(bus.req_o), 64'(ereq));
    check({tag, " no_st_pending"}, 64'(bus.no_st_pending_o), 64'(ensp));
  endtask

  task automatic check_head(input string tag, input int id);
    check({tag, " addr"}, 64'(bus.addr_o), 64'(addr_of(id)));
    check({tag, " wdata"}, 64'(bus.wdata_o), 64'(data_of(id)));
    check({tag, " be"}, 64'(bus.be_o), 64'(be_of(id)));
  endtask

  task automatic drive(input bit v, input bit c, input bit g, input bit f, input int st);
    bus.valid_i  = v;
    bus.commit_i = c;
    bus.gnt_i    = g;
    bus.flush_i  = f;
    bus.paddr_i  = v ? addr_of(st) : '0;
    bus.data_i   = v ? data_of(st) : '0;
    bus.be_i     = v ? be_of(st) : '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    int sent;
    int got;
    checks   = 0;
    failures = 0;
    rst_ni   = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Columns: valid commit gnt flush store | ready commit_ready req no_st_pending head
    // Single store: allocate, commit, stall the D$ three cycles, then grant.
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, -1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 1, -1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 1));
    // Fill all four entries.
    vecs.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, 1, -1));
    vecs.push_back(mk(1, 0, 0, 0, 3, 1, 1, 0, 1, -1));
    vecs.push_back(mk(1, 0, 0, 0, 4, 1, 1, 0, 1, -1));
    vecs.push_back(mk(1, 0, 0, 0, 5, 1, 1, 0, 1, -1));
    // Full: commit one, then a fifth store must be ignored.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, -1));
    vecs.push_back(mk(1, 0, 0, 0, 6, 0, 1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 2));
    // Space freed by the grant shows up now; drain the rest, store 6 must not appear.
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 1, -1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 0, 3));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 0, 4));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, -1));

    step();
    step();
    rst_ni = 1'b1;
    step();
    check_status("reset", 1, 0, 0, 1);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      check_status(tag, vecs[i].e_ready, vecs[i].e_cr, vecs[i].e_req, vecs[i].e_nsp);
      if (vecs[i].e_head >= 0) check_head(tag, vecs[i].e_head);
      drive(vecs[i].valid, vecs[i].commit, vecs[i].gnt, vecs[i].flush, vecs[i].st);
      step();
    end

    // Flush: three speculative stores, commit + flush (+ dropped allocate) together.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 10 + k);
      step();
    end
    check_status("pre_flush", 1, 1, 0, 1);
    drive(1, 1, 0, 1, 13);
    step();
    check_status("post_flush", 1, 0, 1, 0);
    check_head("post_flush", 10);
    drive(1, 0, 1, 0, 14);
    step();
    check_status("flush_realloc", 1, 1, 0, 1);
    drive(0, 1, 0, 0, 0);
    step();
    check_status("flush_commit", 1, 0, 1, 0);
    check_head("flush_commit", 14);
    drive(0, 0, 1, 0, 0);
    step();
    check_status("flush_done", 1, 0, 0, 1);

    // Wrap-around stream: commit and grant held high.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (bus.req_o) begin
        if (got < 10) check_head($sformatf("stream%0d", got), 20 + got);
        else check("stream extra req", 64'(got), 64'd9);
        got++;
      end
      if (sent < 10) begin
        check($sformatf("stream ready%0d", sent), 64'(bus.ready_o), 64'd1);
        drive(1, 1, 1, 0, 20 + sent);
        sent++;
      end else begin
        drive(0, 1, 1, 0, 0);
      end
      step();
    end
    drive(0, 0, 0, 0, 0);
    check("stream count", 64'(got), 64'd10);
    check_status("stream_end", 1, 0, 0, 1);

    // Reset mid-drain with two committed entries.
    drive(1, 0, 0, 0, 30);
    step();
    drive(1, 1, 0, 0, 31);
    step();
    drive(0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check_status("pre_reset", 1, 0, 1, 0);
    check_head("pre_reset", 30);
    #2;
    rst_ni = 1'b0;
    #1;
    check_status("in_reset", 1, 0, 0, 1);
    step();
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_status($sformatf("after_reset%0d", k), 1, 0, 0, 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
